// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline enable/flush control for the 5-stage MIPS datapath.
// Holds EX and ID redirect requests until a fetch (ihit) consumes the flush,
// inserts load-use bubbles, freezes the front end during data-memory waits,
// and enters a sticky HALTED state when a HALT reaches MEM/WB.
// Optional build macro: HAZ_PERF_EN adds saturating stall_cnt / flush_cnt.
module hazard_ctrl #(
  parameter int unsigned REGW = 5
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic            exmem_dREN,
  input  logic            exmem_dWEN,
  input  logic            idex_dREN,
  input  logic [REGW-1:0] idex_dest,
  input  logic [REGW-1:0] ifid_rs,
  input  logic [REGW-1:0] ifid_rt,
  input  logic            ifid_uses_rt,
  input  logic            jump_id,
  input  logic            branch_ex,
  input  logic            halt_wb,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            ifid_flush,
  output logic            idex_en,
  output logic            idex_flush,
  output logic            exmem_en,
  output logic            exmem_flush,
  output logic            memwb_en,
  output logic            memwb_flush,
  output logic            halt
`ifdef HAZ_PERF_EN
  ,
  output logic [15:0]     stall_cnt,
  output logic [15:0]     flush_cnt
`endif
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   pend_id_q, pend_id_d;
  logic   pend_ex_q, pend_ex_d;

  logic   mem_busy;
  logic   redir_ex;
  logic   redir_id;
  logic   load_use;
  logic   consume;

  // Hazard condition decode shared by outputs and next-state logic
  always_comb begin
    mem_busy = (exmem_dREN | exmem_dWEN) & ~dhit;
    redir_ex = branch_ex | pend_ex_q;
    redir_id = jump_id | pend_id_q;
    load_use = idex_dREN & (idex_dest != '0) &
               ((idex_dest == ifid_rs) | (ifid_uses_rt & (idex_dest == ifid_rt)));
    consume  = ihit & ~mem_busy;
  end

  // Per-stage enables/flushes; first matching hazard rule wins
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    memwb_flush = 1'b0;
    halt        = 1'b0;
    if (!nRST) begin
      // everything held low while reset is asserted
    end else if (state_q == HALTED) begin
      halt = 1'b1;
    end else if (mem_busy) begin
      memwb_en    = 1'b1;
      memwb_flush = 1'b1;
    end else if (redir_ex) begin
      pc_en      = ihit;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = ihit;
      memwb_en   = ihit;
    end else if (redir_id) begin
      pc_en      = ihit;
      ifid_flush = 1'b1;
      idex_en    = ihit;
      exmem_en   = ihit;
      memwb_en   = ihit;
    end else if (load_use) begin
      idex_flush = 1'b1;
      exmem_en   = ihit;
      memwb_en   = ihit;
    end else begin
      pc_en    = ihit;
      ifid_en  = ihit;
      idex_en  = ihit;
      exmem_en = ihit;
      memwb_en = ihit;
    end
  end

  // Next state and pending-redirect bookkeeping
  always_comb begin
    state_d   = state_q;
    pend_id_d = pend_id_q;
    pend_ex_d = pend_ex_q;
    if (state_q == RUN) begin
      if (halt_wb) state_d = HALTED;
      pend_ex_d = redir_ex & ~consume;
      pend_id_d = redir_id & ~consume & ~redir_ex;
    end
  end

  // State and pending-bit registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= RUN;
      pend_id_q <= 1'b0;
      pend_ex_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_id_q <= pend_id_d;
      pend_ex_q <= pend_ex_d;
    end
  end

`ifdef HAZ_PERF_EN
  logic        stall_evt;
  logic        flush_evt;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Event qualification and saturating increment for the perf counters
  always_comb begin
    stall_evt   = (state_q == RUN) &
                  (mem_busy | (~redir_ex & ~redir_id & load_use));
    flush_evt   = (state_q == RUN) & consume & (redir_ex | redir_id);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = 16'(stall_cnt_q + 16'd1);
    if (flush_evt && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = 16'(flush_cnt_q + 16'd1);
  end

  // Perf counter registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table-driven stimulus per scenario,
// expected output vectors queued at drive time and popped when sampled.
module tb_hazard_ctrl;

  logic       CLK;
  logic       nRST;
  logic       ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN;
  logic [4:0] idex_dest, ifid_rs, ifid_rt;
  logic       ifid_uses_rt, jump_id, branch_ex, halt_wb;
  logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic       exmem_en, exmem_flush, memwb_en, memwb_flush, halt;
`ifdef HAZ_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl #(.REGW(5)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN), .idex_dREN(idex_dREN),
    .idex_dest(idex_dest), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .jump_id(jump_id), .branch_ex(branch_ex),
    .halt_wb(halt_wb), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .exmem_flush(exmem_flush), .memwb_en(memwb_en), .memwb_flush(memwb_flush),
    .halt(halt)
`ifdef HAZ_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {halt, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush}
  localparam logic [9:0] ZERO = 10'b0000000000;
  localparam logic [9:0] NORM = 10'b0110101010;
  localparam logic [9:0] LU   = 10'b0000011010;
  localparam logic [9:0] EX0  = 10'b0001010000;
  localparam logic [9:0] EX1  = 10'b0101011010;
  localparam logic [9:0] ID0  = 10'b0001000000;
  localparam logic [9:0] ID1  = 10'b0101101010;
  localparam logic [9:0] BUSY = 10'b0000000011;
  localparam logic [9:0] HLT  = 10'b1000000000;

  typedef struct packed {
    logic       ih, dh, exr, exw, idr;
    logic [4:0] dst, rs, rt;
    logic       urt, jmp, br, hw;
    logic [9:0] exp;
  } stim_t;

  logic [9:0] obs;
  assign obs = {halt, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                exmem_en, exmem_flush, memwb_en, memwb_flush};

  int total = 0;
  int bad   = 0;
  logic [9:0] sb[$];

  function automatic stim_t st(input logic ih, dh, exr, exw, idr,
                               input logic [4:0] dst, rs, rt,
                               input logic urt, jmp, br, hw,
                               input logic [9:0] exp);
    stim_t s;
    s = '{ih, dh, exr, exw, idr, dst, rs, rt, urt, jmp, br, hw, exp};
    return s;
  endfunction

  task automatic apply(input stim_t s);
    ihit = s.ih; dhit = s.dh; exmem_dREN = s.exr; exmem_dWEN = s.exw;
    idex_dREN = s.idr; idex_dest = s.dst; ifid_rs = s.rs; ifid_rt = s.rt;
    ifid_uses_rt = s.urt; jump_id = s.jmp; branch_ex = s.br; halt_wb = s.hw;
  endtask

  task automatic test_reset();
    logic [9:0] e;
    @(negedge CLK);
    nRST = 1'b0;
    apply(st(1,1,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, ZERO));
    sb.push_back(ZERO);
    #1 e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL reset_hold got=%b exp=%b", obs, e); end
    @(negedge CLK);
    nRST = 1'b1;
    sb.push_back(NORM);
    #1 e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL reset_release got=%b exp=%b", obs, e); end
  endtask

  task automatic test_load_use();
    stim_t steps[$];
    logic [9:0] e;
    steps.push_back(st(1,1,0,0,1, 5'd8,5'd8,5'd0, 0,0,0,0, LU));
    steps.push_back(st(1,1,0,0,0, 5'd8,5'd8,5'd0, 0,0,0,0, NORM));
    steps.push_back(st(1,1,0,0,1, 5'd8,5'd3,5'd8, 1,0,0,0, LU));
    steps.push_back(st(1,1,0,0,1, 5'd8,5'd3,5'd8, 0,0,0,0, NORM));
    steps.push_back(st(1,1,0,0,1, 5'd0,5'd0,5'd0, 1,0,0,0, NORM));
    steps.push_back(st(0,1,0,0,1, 5'd8,5'd8,5'd0, 0,0,0,0, 10'b0000010000));
    foreach (steps[i]) begin
      @(negedge CLK);
      apply(steps[i]);
      sb.push_back(steps[i].exp);
      #1 e = sb.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL load_use step=%0d got=%b exp=%b", i, obs, e); end
    end
  endtask

  task automatic test_branch_imiss();
    stim_t steps[$];
    logic [9:0] e;
    steps.push_back(st(0,1,0,0,0, 5'd0,5'd0,5'd0, 0,0,1,0, EX0));
    steps.push_back(st(0,1,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, EX0));
    steps.push_back(st(0,1,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, EX0));
    steps.push_back(st(1,1,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, EX1));
    steps.push_back(st(1,1,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, NORM));
    steps.push_back(st(0,1,0,0,0, 5'd0,5'd0,5'd0, 0,1,0,0, ID0));
    steps.push_back(st(1,1,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, ID1));
    steps.push_back(st(0,1,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, ZERO));
    foreach (steps[i]) begin
      @(negedge CLK);
      apply(steps[i]);
      sb.push_back(steps[i].exp);
      #1 e = sb.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL branch_imiss step=%0d got=%b exp=%b", i, obs, e); end
    end
  endtask

  task automatic test_dwait();
    stim_t steps[$];
    logic [9:0] e;
    steps.push_back(st(1,0,1,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, BUSY));
    steps.push_back(st(1,0,1,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, BUSY));
    steps.push_back(st(1,1,1,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, NORM));
    steps.push_back(st(0,1,1,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, ZERO));
    // branch arriving during a store wait must survive until the wait ends
    steps.push_back(st(1,0,0,1,1, 5'd8,5'd8,5'd0, 0,0,1,0, BUSY));
    steps.push_back(st(1,1,0,1,0, 5'd0,5'd0,5'd0, 0,0,0,0, EX1));
    steps.push_back(st(1,1,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, NORM));
    foreach (steps[i]) begin
      @(negedge CLK);
      apply(steps[i]);
      sb.push_back(steps[i].exp);
      #1 e = sb.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL dwait step=%0d got=%b exp=%b", i, obs, e); end
    end
  endtask

  task automatic test_jump_branch();
    stim_t steps[$];
    logic [9:0] e;
    steps.push_back(st(1,1,0,0,0, 5'd0,5'd0,5'd0, 0,1,1,0, EX1));
    steps.push_back(st(1,1,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, NORM));
    steps.push_back(st(0,1,0,0,0, 5'd0,5'd0,5'd0, 0,1,1,0, EX0));
    steps.push_back(st(1,1,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, EX1));
    steps.push_back(st(0,1,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, ZERO));
    // redirect outranks a simultaneous load-use hazard
    steps.push_back(st(1,1,0,0,1, 5'd4,5'd4,5'd0, 0,1,0,0, ID1));
    foreach (steps[i]) begin
      @(negedge CLK);
      apply(steps[i]);
      sb.push_back(steps[i].exp);
      #1 e = sb.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL jump_branch step=%0d got=%b exp=%b", i, obs, e); end
    end
  endtask

  task automatic test_halt();
    stim_t steps[$];
    logic [9:0] e;
    steps.push_back(st(1,0,1,0,0, 5'd0,5'd0,5'd0, 0,0,0,1, BUSY));
    steps.push_back(st(1,1,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, HLT));
    steps.push_back(st(1,1,0,0,0, 5'd0,5'd0,5'd0, 0,1,1,0, HLT));
    foreach (steps[i]) begin
      @(negedge CLK);
      apply(steps[i]);
      sb.push_back(steps[i].exp);
      #1 e = sb.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL halt step=%0d got=%b exp=%b", i, obs, e); end
    end
    @(negedge CLK);
    apply(st(1,1,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, ZERO));
    nRST = 1'b0;
    sb.push_back(ZERO);
    #1 e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL halt_reset got=%b exp=%b", obs, e); end
    @(negedge CLK);
    nRST = 1'b1;
    sb.push_back(NORM);
    #1 e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL halt_release got=%b exp=%b", obs, e); end
  endtask

  task automatic test_reset_mid_stall();
    logic [9:0] e;
    @(negedge CLK);
    apply(st(0,1,0,0,0, 5'd0,5'd0,5'd0, 0,1,1,0, EX0));
    sb.push_back(EX0);
    #1 e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL mid_stall_set got=%b exp=%b", obs, e); end
    @(negedge CLK);
    apply(st(0,1,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, ZERO));
    nRST = 1'b0;
    #2 nRST = 1'b1;
    @(negedge CLK);
    apply(st(1,1,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, NORM));
    sb.push_back(NORM);
    #1 e = sb.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL mid_stall_cleared got=%b exp=%b", obs, e); end
  endtask

  initial begin
    nRST = 1'b0;
    apply(st(0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,0,0, ZERO));
    test_reset();
    test_load_use();
    test_branch_imiss();
    test_dwait();
    test_jump_branch();
    test_halt();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
